// File: rtl/uart_ser_pkg.sv
// Shared types, parity constants and the data-length clamp for the UART frame serializer.
package uart_ser_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } ser_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // A length of zero or one larger than the datapath means "use the full width".
  function automatic int clamp_len(input int len, input int width);
    return ((len == 0) || (len > width)) ? width : len;
  endfunction

endpackage

// File: rtl/uart_parity_calc.sv
// Parity over the low i_len bits of i_data; i_odd selects odd parity instead of even.
module uart_parity_calc
  import uart_ser_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_odd,
  output logic             o_parity
);

  logic [WIDTH-1:0] w_mask;

  for (genvar g = 0; g < WIDTH; g++) begin : g_mask
    assign w_mask[g] = (g < int'(i_len));
  end

  assign o_parity = (^(i_data & w_mask)) ^ (i_odd == PAR_ODD);

endmodule

// File: rtl/uart_frame_serializer.sv
// UART TX frame engine with a one-word holding buffer, paced by Bit_Tick.
// Parity support is built only when UART_SER_PARITY_EN is defined.
module uart_frame_serializer
  import uart_ser_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DATA,
  input  logic             Data_Valid,
  output logic             Ready,
  input  logic             Bit_Tick,
  input  logic [LEN_W-1:0] Data_Len,
  input  logic             Msb_First,
  input  logic             Par_En,
  input  logic             Par_Type,
  input  logic             Stop2,
  output logic             ser_out,
  output logic             Busy,
  output logic             ser_done,
  output logic [2:0]       o_dbg_state
);

  // Handshake: a word transfers on any CLK edge where Data_Valid && Ready; Ready is
  // purely registered (!r_hold_full), so it never depends on Data_Valid in the same cycle.
  ser_state_t       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_hold_data, r_data;
  logic             r_hold_full;
  logic [LEN_W-1:0] r_len, r_bit_cnt, w_cnt_nxt;
  logic             r_msb, r_stop2, r_stop_cnt, w_stop_nxt;
  logic             r_ser_out, w_line_nxt, r_done, w_done;
  logic             w_load, w_accept, w_last, w_bit;
  logic [LEN_W-1:0] w_idx, w_pos;
  logic [WIDTH-1:0] w_shifted;
  logic             w_par_bit, w_par_go;

  assign w_accept    = Data_Valid && !r_hold_full;
  assign Ready       = !r_hold_full;
  assign Busy        = (r_state != S_IDLE) || r_hold_full;
  assign ser_out     = r_ser_out;
  assign ser_done    = r_done;
  assign o_dbg_state = r_state;

  // The frame word stays put; the next bit is selected by index instead of shifting.
  assign w_last    = (r_bit_cnt == (r_len - 1'b1));
  assign w_idx     = (r_state == S_START) ? '0 : (r_bit_cnt + 1'b1);
  assign w_pos     = r_msb ? (r_len - 1'b1 - w_idx) : w_idx;
  assign w_shifted = r_data >> w_pos;
  assign w_bit     = w_shifted[0];

`ifdef UART_SER_PARITY_EN
  logic r_par_en, r_par_type;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_par_en   <= 1'b0;
      r_par_type <= PAR_EVEN;
    end else if (w_load) begin
      r_par_en   <= Par_En;
      r_par_type <= Par_Type;
    end
  end

  uart_parity_calc #(
    .WIDTH(WIDTH),
    .LEN_W(LEN_W)
  ) u_parity (
    .i_data  (r_data),
    .i_len   (r_len),
    .i_odd   (r_par_type),
    .o_parity(w_par_bit)
  );

  assign w_par_go = r_par_en;
`else
  logic w_unused_par;
  assign w_unused_par = Par_En ^ Par_Type;
  assign w_par_bit    = 1'b0;
  assign w_par_go     = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // w_line_nxt is the line value for the state being entered, so ser_out moves one cycle after each tick.
  always_comb begin
    w_state_nxt = r_state;
    w_line_nxt  = r_ser_out;
    w_cnt_nxt   = r_bit_cnt;
    w_stop_nxt  = r_stop_cnt;
    w_load      = 1'b0;
    w_done      = 1'b0;
    if (Bit_Tick) begin
      case (r_state)
        S_IDLE: begin
          if (r_hold_full) begin
            w_load      = 1'b1;
            w_state_nxt = S_START;
            w_line_nxt  = 1'b0;
          end else begin
            w_line_nxt  = 1'b1;
          end
        end
        S_START: begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = '0;
          w_line_nxt  = w_bit;
        end
        S_DATA: begin
          if (w_last) begin
            w_stop_nxt = 1'b0;
            if (w_par_go) begin
              w_state_nxt = S_PARITY;
              w_line_nxt  = w_par_bit;
            end else begin
              w_state_nxt = S_STOP;
              w_line_nxt  = 1'b1;
            end
          end else begin
            w_cnt_nxt  = r_bit_cnt + 1'b1;
            w_line_nxt = w_bit;
          end
        end
`ifdef UART_SER_PARITY_EN
        S_PARITY: begin
          w_state_nxt = S_STOP;
          w_stop_nxt  = 1'b0;
          w_line_nxt  = 1'b1;
        end
`endif
        S_STOP: begin
          if (r_stop2 && !r_stop_cnt) begin
            w_stop_nxt = 1'b1;
            w_line_nxt = 1'b1;
          end else begin
            w_done     = 1'b1;
            w_stop_nxt = 1'b0;
            if (r_hold_full) begin
              w_load      = 1'b1;
              w_state_nxt = S_START;
              w_line_nxt  = 1'b0;
            end else begin
              w_state_nxt = S_IDLE;
              w_line_nxt  = 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_line_nxt  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_hold_full <= 1'b0;
      r_hold_data <= '0;
      r_data      <= '0;
      r_len       <= '0;
      r_msb       <= 1'b0;
      r_stop2     <= 1'b0;
      r_bit_cnt   <= '0;
      r_stop_cnt  <= 1'b0;
      r_ser_out   <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      r_bit_cnt  <= w_cnt_nxt;
      r_stop_cnt <= w_stop_nxt;
      r_ser_out  <= w_line_nxt;
      r_done     <= w_done;
      if (w_accept) begin
        r_hold_full <= 1'b1;
        r_hold_data <= DATA;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end
      if (w_load) begin
        r_data  <= r_hold_data;
        r_len   <= LEN_W'(clamp_len(int'(Data_Len), WIDTH));
        r_msb   <= Msb_First;
        r_stop2 <= Stop2;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_serializer.sv
// Self-checking bench for uart_frame_serializer: directed frames plus random traffic
// compared cycle by cycle against a frame-level reference model.
module tb_uart_frame_serializer;

  localparam int WIDTH = 8;
  localparam int LEN_W = $clog2(WIDTH + 1);

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic [WIDTH-1:0] DATA = '0;
  logic             Data_Valid = 1'b0;
  logic             Bit_Tick = 1'b0;
  logic [LEN_W-1:0] Data_Len = '0;
  logic             Msb_First = 1'b0;
  logic             Par_En = 1'b0;
  logic             Par_Type = 1'b0;
  logic             Stop2 = 1'b0;
  logic             Ready, ser_out, Busy, ser_done;
  logic [2:0]       dbg_state;

  uart_frame_serializer #(.WIDTH(WIDTH)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .DATA       (DATA),
    .Data_Valid (Data_Valid),
    .Ready      (Ready),
    .Bit_Tick   (Bit_Tick),
    .Data_Len   (Data_Len),
    .Msb_First  (Msb_First),
    .Par_En     (Par_En),
    .Par_Type   (Par_Type),
    .Stop2      (Stop2),
    .ser_out    (ser_out),
    .Busy       (Busy),
    .ser_done   (ser_done),
    .o_dbg_state(dbg_state)
  );

  // clock
  always #5 CLK = ~CLK;

  // reference model state
  logic             exp_q[$];
  logic [WIDTH-1:0] word_q[$];
  logic             exp_line = 1'b1;
  logic             exp_done = 1'b0;
  bit               in_frame = 1'b0;
  bit               acc_now = 1'b0;
  int               done_cnt = 0;
  int               n_checks = 0;
  int               n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Line values of a whole frame, built from the current config as sampled at frame start.
  function automatic void push_frame(input logic [WIDTH-1:0] w);
    int   len;
    int   ones;
    logic b;
    ones = 0;
    len  = ((Data_Len == 0) || (int'(Data_Len) > WIDTH)) ? WIDTH : int'(Data_Len);
    exp_q.push_back(1'b0);
    for (int i = 0; i < len; i++) begin
      b = w[Msb_First ? (len - 1 - i) : i];
      ones += int'(b);
      exp_q.push_back(b);
    end
`ifdef UART_SER_PARITY_EN
    if (Par_En) exp_q.push_back(1'(ones % 2) ^ Par_Type);
`endif
    exp_q.push_back(1'b1);
    if (Stop2) exp_q.push_back(1'b1);
  endfunction

  function automatic void model_edge();
    bit hold;
    exp_done = 1'b0;
    acc_now  = 1'b0;
    if (!RST) begin
      exp_q.delete();
      word_q.delete();
      exp_line = 1'b1;
      in_frame = 1'b0;
    end else begin
      hold = (word_q.size() != 0);
      if (Bit_Tick) begin
        if (exp_q.size() != 0) begin
          exp_line = exp_q.pop_front();
        end else begin
          if (in_frame) begin
            exp_done = 1'b1;
            in_frame = 1'b0;
          end
          if (hold) begin
            push_frame(word_q.pop_front());
            exp_line = exp_q.pop_front();
            in_frame = 1'b1;
          end else begin
            exp_line = 1'b1;
          end
        end
      end
      if (Data_Valid && !hold) begin
        word_q.push_back(DATA);
        acc_now = 1'b1;
      end
    end
  endfunction

  // One clock: model follows the edge, outputs are compared on the falling edge.
  task automatic step();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    check_eq("ser_out", ser_out, exp_line);
    check_eq("ready", Ready, word_q.size() == 0);
    check_eq("busy", Busy, in_frame || (word_q.size() != 0));
    check_eq("ser_done", ser_done, exp_done);
    if (ser_done) done_cnt++;
    if (acc_now) Data_Valid = 1'b0;
  endtask

  task automatic send(input logic [WIDTH-1:0] w);
    int guard;
    guard = 0;
    while (!Ready && guard < 100) begin
      step();
      guard++;
    end
    check_eq("send_ready", Ready, 1'b1);
    DATA       = w;
    Data_Valid = 1'b1;
    step();
  endtask

  // n recorded ticks, then one more tick that should close the frame.
  task automatic run_seq(input string tag, input int n, input logic [31:0] exp_seq, input int exp_dones);
    logic [31:0] seq;
    int          d0;
    seq = '0;
    d0  = done_cnt;
    for (int i = 0; i <= n; i++) begin
      Bit_Tick = 1'b1;
      step();
      Bit_Tick = 1'b0;
      if (i < n) seq = {seq[30:0], ser_out};
      step();
    end
    check_eq(tag, seq, exp_seq);
    check_eq({tag, "_dones"}, done_cnt - d0, exp_dones);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      Bit_Tick = 1'b1;
      step();
      Bit_Tick = 1'b0;
      step();
    end
  endtask

  initial begin
    int d0;

    RST = 1'b0;
    repeat (3) step();
    check_eq("rst_line", ser_out, 1'b1);
    check_eq("rst_ready", Ready, 1'b1);
    check_eq("rst_busy", Busy, 1'b0);
    RST = 1'b1;
    step();

    // A5, 8 bits LSB-first, even parity, 1 stop
    Data_Len = 4'd8; Msb_First = 1'b0; Par_En = 1'b1; Par_Type = 1'b0; Stop2 = 1'b0;
    send(8'hA5);
`ifdef UART_SER_PARITY_EN
    run_seq("a5_lsb_even", 11, 32'b01010010101, 1);
`else
    run_seq("a5_lsb", 10, 32'b0101001011, 1);
`endif

    // 13, 5 bits MSB-first, odd parity, 2 stops
    Data_Len = 4'd5; Msb_First = 1'b1; Par_En = 1'b1; Par_Type = 1'b1; Stop2 = 1'b1;
    send(8'h13);
`ifdef UART_SER_PARITY_EN
    run_seq("h13_msb_odd", 9, 32'b010011011, 1);
`else
    run_seq("h13_msb", 8, 32'b01001111, 1);
`endif

    // back-to-back frames leave no idle tick
    Data_Len = 4'd8; Msb_First = 1'b0; Par_En = 1'b0; Par_Type = 1'b0; Stop2 = 1'b0;
    send(8'h01);
    check_eq("b2b_ready_low", Ready, 1'b0);
    DATA       = 8'h80;
    Data_Valid = 1'b1;
    run_seq("b2b", 20, 32'b01000000010000000011, 2);

    // out-of-range lengths fall back to the full width
    Data_Len = 4'd0;
    send(8'hFF);
    run_seq("len0", 10, 32'b0111111111, 1);
    Data_Len = 4'd12;
    send(8'hFF);
    run_seq("len12", 10, 32'b0111111111, 1);

    // long tick gap mid-DATA: line holds data bit 3 of 5A (=1)
    Data_Len = 4'd8;
    send(8'h5A);
    ticks(5);
    repeat (20) begin
      step();
      check_eq("gap_hold", ser_out, 1'b1);
    end
    d0 = done_cnt;
    ticks(6);
    check_eq("gap_done", done_cnt - d0, 1);

    // reset during data bit 3
    send(8'hC3);
    ticks(5);
    d0  = done_cnt;
    RST = 1'b0;
    step();
    check_eq("mid_rst_line", ser_out, 1'b1);
    check_eq("mid_rst_busy", Busy, 1'b0);
    check_eq("mid_rst_ready", Ready, 1'b1);
    RST = 1'b1;
    repeat (4) step();
    check_eq("mid_rst_nodone", done_cnt - d0, 0);

    // random traffic, config and occasional reset
    for (int c = 0; c < 3000; c++) begin
      Bit_Tick = ($urandom_range(0, 2) == 0);
      if (!Data_Valid && $urandom_range(0, 3) == 0) begin
        Data_Valid = 1'b1;
        DATA       = WIDTH'($urandom);
      end
      if ($urandom_range(0, 40) == 0) begin
        Data_Len  = LEN_W'($urandom_range(0, 15));
        Msb_First = 1'($urandom_range(0, 1));
        Par_En    = 1'($urandom_range(0, 1));
        Par_Type  = 1'($urandom_range(0, 1));
        Stop2     = 1'($urandom_range(0, 1));
      end
      RST = ($urandom_range(0, 999) != 0);
      step();
    end
    RST        = 1'b1;
    Data_Valid = 1'b0;
    ticks(40);
    check_eq("drain_busy", Busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_frame_serializer.md
# uart_frame_serializer

Parametrised UART transmit frame engine: accepts a parallel word through a valid/ready handshake and shifts out a complete asynchronous frame (start, 1..WIDTH data bits, optional parity, 1 or 2 stop bits) paced by an external baud tick. It is the next generation of the TX serializer: it generalises data length and bit order, adds parity and stop-bit control, and adds a one-entry holding buffer so back-to-back frames leave no idle gap. It sits between the TX host interface and the TX line driver, fed by the baud generator's tick.

## Interface
- WIDTH, 8, maximum data bits per frame (≥2)
- LEN_W, $clog2(WIDTH+1), width of Data_Len (derived, not overridden)
- CLK  in  1  clock; all logic on posedge
- RST  in  1  reset, synchronous, active-low
- DATA  in  WIDTH  word to transmit
- Data_Valid  in  1  DATA valid; transfer when Data_Valid && Ready at a CLK edge
- Ready  out  1  holding buffer empty
- Bit_Tick  in  1  one-cycle baud strobe; the FSM advances only on cycles with Bit_Tick=1
- Data_Len  in  LEN_W  data bits per frame; 0 or >WIDTH is treated as WIDTH
- Msb_First  in  1  1: send DATA[len-1] first; 0: send DATA[0] first
- Par_En  in  1  append parity bit
- Par_Type  in  1  0 even, 1 odd
- Stop2  in  1  two stop bits
- ser_out  out  1  serial line, registered
- Busy  out  1  frame in progress or holding buffer full
- ser_done  out  1  one-cycle pulse at end of last stop bit

## Operation
- Holding register (hold_data, hold_full). Accept sets hold_full; Ready = !hold_full, driven from register only (no combinational path from Data_Valid).
- Config (Data_Len, Msb_First, Par_En, Par_Type, Stop2) is sampled into the frame registers at frame start and held constant for the frame.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: ser_out=1. On Bit_Tick with hold_full: shift_reg<=hold_data, latch config, hold_full<=0, go to START.
- START: ser_out=0 for one tick period; on Bit_Tick go to DATA, bit_cnt<=0.
- DATA: ser_out = current bit. On Bit_Tick: shift (right for LSB-first, left-rotate toward bit len-1 for MSB-first), bit_cnt+1; when bit_cnt==len-1 go to PARITY if Par_En else STOP.
- PARITY: ser_out = XOR of the len transmitted bits (inverted for odd). On Bit_Tick go to STOP.
- STOP: ser_out=1 for 1 or 2 ticks. On the final tick: pulse ser_done; go to START if hold_full (no gap) else IDLE.
- Busy = (state != IDLE) || hold_full.
- Bits above len in DATA are ignored, including for parity.

## Timing
- Reset (RST=0 at an edge): ser_out=1, Ready=1, Busy=0, ser_done=0, hold_full=0, state IDLE, counters 0. Mid-frame reset aborts the frame; line is 1 from the next edge.
- Accept→Ready low: next cycle. Frame-start tick→ser_out=0: next cycle.
- Line changes exactly one cycle after each Bit_Tick; stable while Bit_Tick=0.
- Frame length = 1 + len + Par_En + (Stop2 ? 2 : 1) ticks.
- Accept in the same cycle the buffer drains is impossible (Ready registered); the buffer reopens the cycle after transfer.

## Configuration
- UART_SER_PARITY_EN defined: PARITY state and parity logic present as above.
- Undefined: Par_En and Par_Type are ignored, the PARITY state and parity logic are not built, and DATA always goes to STOP.

## Structure
- uart_ser_pkg: state enum type (IDLE/START/DATA/PARITY/STOP), parity-type constants PAR_EVEN=0/PAR_ODD=1, len-clamp function.
- Sub-module uart_parity_calc: masked XOR reduction of WIDTH data bits with len mask and odd select; instantiated only under UART_SER_PARITY_EN.

## Test plan
- WIDTH=8, DATA=8'hA5, len 8, LSB-first, even parity, 1 stop -> line 0,1,0,1,0,0,1,0,1,0,1 over 11 ticks; one ser_done.
- DATA=8'h13, len 5, MSB-first, odd parity, Stop2 -> line 0,1,0,0,1,1,0,1,1 (9 ticks).
- Two words 8'h01, 8'h80 accepted back-to-back, no parity -> second start bit on the tick directly after the first stop bit; Ready low until the first frame starts.
- Data_Len=0 and Data_Len=12 with DATA=8'hFF -> both send 8 data bits.
- Bit_Tick held low 20 cycles mid-DATA -> ser_out constant; resumes correctly.
- RST low during bit 3 of a frame -> next edge ser_out=1, Busy=0, Ready=1, no ser_done.
